// File: rtl/pic_host_master.sv
// CPU-side bus initiator for an 8259-style PIC: sequences register write/read
// cycles from a valid/ready command port and runs the two-pulse INTA acknowledge.
module pic_host_master #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1,
  parameter bit          AUTO_EOI_CMD  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       int_in,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [7:0] vec_data,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a0,
  output logic       inta_n,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  output logic       busy
);

  localparam int unsigned MAXC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_INTA1, S_IGAP, S_INTA2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_write, w_write_nxt;
  logic          r_a0, w_a0_nxt;
  logic [7:0]    r_wdata, w_wdata_nxt;
  logic          r_eoi, w_eoi_nxt;
  logic          r_int_meta, r_int_s;
  logic          r_vec_valid;
  logic [7:0]    r_vec_data;
  logic [7:0]    r_rdata;
  logic          w_cnt_last;

  // Pins are registered from the next-state decode so they toggle glitch-free
  // on the same edge the state changes.
  logic          r_cs_n, r_rd_n, r_wr_n, r_a0_pin, r_inta_n, r_d_oe, r_rsp_valid;
  logic [7:0]    r_d_out;
  logic          w_cs_n, w_rd_n, w_wr_n, w_a0_pin, w_inta_n, w_d_oe, w_rsp_valid;
  logic [7:0]    w_d_out;
  logic          w_bus;

  assign w_cnt_last = (r_cnt == '0);
  assign cmd_ready  = (r_state == S_IDLE) && !(r_int_s && !r_vec_valid);
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_write_nxt = r_write;
    w_a0_nxt    = r_a0;
    w_wdata_nxt = r_wdata;
    w_eoi_nxt   = r_eoi;
    case (r_state)
      S_IDLE: begin
        if (r_int_s && !r_vec_valid) begin
          w_state_nxt = S_INTA1;
          w_cnt_nxt   = CW'(STROBE_CYCLES - 1);
        end else if (cmd_valid) begin
          w_state_nxt = S_SETUP;
          w_write_nxt = cmd_write;
          w_a0_nxt    = cmd_a0;
          w_wdata_nxt = cmd_wdata;
          w_eoi_nxt   = 1'b0;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_STROBE;
        w_cnt_nxt   = CW'(STROBE_CYCLES - 1);
      end
      S_STROBE: begin
        if (w_cnt_last) w_state_nxt = S_HOLD;
        else            w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_HOLD: begin
        w_state_nxt = S_RECOVER;
        w_cnt_nxt   = CW'(GAP_CYCLES - 1);
      end
      S_RECOVER: begin
        if (w_cnt_last) w_state_nxt = S_IDLE;
        else            w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_INTA1: begin
        if (w_cnt_last) begin
          w_state_nxt = S_IGAP;
          w_cnt_nxt   = CW'(GAP_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_IGAP: begin
        if (w_cnt_last) begin
          w_state_nxt = S_INTA2;
          w_cnt_nxt   = CW'(STROBE_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_INTA2: begin
        if (w_cnt_last) begin
          if (AUTO_EOI_CMD) begin
            // Non-specific EOI: OCW2 0x20 at A0=0, reusing the normal write path.
            w_state_nxt = S_SETUP;
            w_write_nxt = 1'b1;
            w_a0_nxt    = 1'b0;
            w_wdata_nxt = 8'h20;
            w_eoi_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_RECOVER;
            w_cnt_nxt   = CW'(GAP_CYCLES - 1);
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_bus       = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) || (w_state_nxt == S_HOLD);
    w_cs_n      = !w_bus;
    w_a0_pin    = w_bus && w_a0_nxt;
    w_d_oe      = w_bus && w_write_nxt;
    w_d_out     = w_d_oe ? w_wdata_nxt : '0;
    w_wr_n      = !((w_state_nxt == S_STROBE) && w_write_nxt);
    w_rd_n      = !((w_state_nxt == S_STROBE) && !w_write_nxt);
    w_inta_n    = !((w_state_nxt == S_INTA1) || (w_state_nxt == S_INTA2));
    w_rsp_valid = (w_state_nxt == S_HOLD) && !w_eoi_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_a0        <= 1'b0;
      r_wdata     <= '0;
      r_eoi       <= 1'b0;
      r_int_meta  <= 1'b0;
      r_int_s     <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_data  <= '0;
      r_rdata     <= '0;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_a0_pin    <= 1'b0;
      r_inta_n    <= 1'b1;
      r_d_oe      <= 1'b0;
      r_d_out     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_write     <= w_write_nxt;
      r_a0        <= w_a0_nxt;
      r_wdata     <= w_wdata_nxt;
      r_eoi       <= w_eoi_nxt;
      r_int_meta  <= int_in;
      r_int_s     <= r_int_meta;
      r_cs_n      <= w_cs_n;
      r_rd_n      <= w_rd_n;
      r_wr_n      <= w_wr_n;
      r_a0_pin    <= w_a0_pin;
      r_inta_n    <= w_inta_n;
      r_d_oe      <= w_d_oe;
      r_d_out     <= w_d_out;
      r_rsp_valid <= w_rsp_valid;
      if (r_state == S_STROBE && w_cnt_last && !r_write) r_rdata <= d_in;
      if (r_vec_valid && vec_ready) r_vec_valid <= 1'b0;
      if (r_state == S_INTA2 && w_cnt_last) begin
        r_vec_valid <= 1'b1;
        r_vec_data  <= d_in;
      end
    end
  end

  assign cs_n      = r_cs_n;
  assign rd_n      = r_rd_n;
  assign wr_n      = r_wr_n;
  assign a0        = r_a0_pin;
  assign inta_n    = r_inta_n;
  assign d_oe      = r_d_oe;
  assign d_out     = r_d_out;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign vec_valid = r_vec_valid;
  assign vec_data  = r_vec_data;

endmodule

// File: tb/tb_pic_host_master.sv
// Bench for pic_host_master: two instances (defaults, and slow strobes with auto-EOI),
// each checked every cycle against a cycle-timeline model plus literal expectations.
module tb_pic_host_master;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NI-1:0] cmd_valid, cmd_write, cmd_a0, int_in, vec_ready;
  logic [7:0]    cmd_wdata [NI];
  logic [7:0]    rd_val    [NI];
  logic [7:0]    vec_val   [NI];

  logic [NI-1:0] cmd_ready, rsp_valid, vec_valid, cs_n, rd_n, wr_n, a0, inta_n, d_oe, busy;
  logic [7:0]    rsp_rdata [NI];
  logic [7:0]    vec_data  [NI];
  logic [7:0]    d_out     [NI];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       cs_n, rd_n, wr_n, inta_n, a0, d_oe;
    logic [7:0] d_out;
    logic       rsp, busy, smp_rd, smp_vec;
  } cyc_t;

  function automatic cyc_t mk(input logic cs, rd, wr, ia, a, oe, input logic [7:0] d,
                              input logic rsp, bsy, sr, sv);
    cyc_t c;
    c.cs_n = cs; c.rd_n = rd; c.wr_n = wr; c.inta_n = ia; c.a0 = a; c.d_oe = oe;
    c.d_out = d; c.rsp = rsp; c.busy = bsy; c.smp_rd = sr; c.smp_vec = sv;
    return c;
  endfunction

  localparam cyc_t C_IDLE = '{cs_n:1'b1, rd_n:1'b1, wr_n:1'b1, inta_n:1'b1, a0:1'b0, d_oe:1'b0,
                              d_out:8'h00, rsp:1'b0, busy:1'b0, smp_rd:1'b0, smp_vec:1'b0};
  localparam cyc_t C_GAP  = '{cs_n:1'b1, rd_n:1'b1, wr_n:1'b1, inta_n:1'b1, a0:1'b0, d_oe:1'b0,
                              d_out:8'h00, rsp:1'b0, busy:1'b1, smp_rd:1'b0, smp_vec:1'b0};

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned SC = (g == 0) ? 2 : 3;
    localparam int unsigned GC = (g == 0) ? 1 : 2;
    localparam bit          AE = (g == 1);

    // PIC stub: first INTA pulse returns 0x00, second returns the vector.
    logic [7:0] din_w;
    int pulses = 0;
    always @(negedge inta_n[g]) pulses++;
    assign din_w = !rd_n[g] ? rd_val[g] : (!inta_n[g] ? (pulses[0] ? 8'h00 : vec_val[g]) : 8'hFF);

    pic_host_master #(.STROBE_CYCLES(SC), .GAP_CYCLES(GC), .AUTO_EOI_CMD(AE)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_a0(cmd_a0[g]), .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .int_in(int_in[g]), .vec_valid(vec_valid[g]), .vec_ready(vec_ready[g]), .vec_data(vec_data[g]),
      .cs_n(cs_n[g]), .rd_n(rd_n[g]), .wr_n(wr_n[g]), .a0(a0[g]), .inta_n(inta_n[g]),
      .d_out(d_out[g]), .d_oe(d_oe[g]), .d_in(din_w), .busy(busy[g])
    );

    // Model: on each transaction start, the whole expected per-cycle pin timeline is queued.
    cyc_t       q[$];
    cyc_t       cur;
    logic       s1, s2, vec_m, vold, dobus, bw, ba, brsp;
    logic [7:0] vdata_m, rdata_m, rd_lat, bd, dd;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        cur = C_IDLE; s1 = 1'b0; s2 = 1'b0; vec_m = 1'b0;
        vdata_m = 8'h00; rdata_m = 8'h00; rd_lat = 8'h00;
      end else begin
        vold = vec_m;
        if (cur.smp_rd) rdata_m = rd_lat;
        if (vec_m && vec_ready[g]) vec_m = 1'b0;
        if (cur.smp_vec) begin vec_m = 1'b1; vdata_m = vec_val[g]; end
        dobus = 1'b0; bw = 1'b0; ba = 1'b0; bd = 8'h00; brsp = 1'b0;
        if (!cur.busy) begin
          if (s2 && !vold) begin
            for (int unsigned i = 0; i < SC; i++)
              q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
            for (int unsigned i = 0; i < GC; i++) q.push_back(C_GAP);
            for (int unsigned i = 0; i < SC; i++)
              q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, i == SC - 1));
            if (AE) begin
              dobus = 1'b1; bw = 1'b1; ba = 1'b0; bd = 8'h20; brsp = 1'b0;
            end else begin
              for (int unsigned i = 0; i < GC; i++) q.push_back(C_GAP);
            end
          end else if (cmd_valid[g]) begin
            dobus = 1'b1; bw = cmd_write[g]; ba = cmd_a0[g]; bd = cmd_wdata[g]; brsp = 1'b1;
            rd_lat = rd_val[g];
          end
        end
        if (dobus) begin
          dd = bw ? bd : 8'h00;
          q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, ba, bw, dd, 1'b0, 1'b1, 1'b0, 1'b0));
          for (int unsigned i = 0; i < SC; i++)
            q.push_back(mk(1'b0, bw, !bw, 1'b1, ba, bw, dd, 1'b0, 1'b1, !bw && (i == SC - 1), 1'b0));
          q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, ba, bw, dd, brsp, 1'b1, 1'b0, 1'b0));
          for (int unsigned i = 0; i < GC; i++) q.push_back(C_GAP);
        end
        s2 = s1; s1 = int_in[g];
        cur = (q.size() != 0) ? q.pop_front() : C_IDLE;
      end
    end

    logic [33:0] exp_v, act_v;
    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        exp_v = {cur.cs_n, cur.rd_n, cur.wr_n, cur.inta_n, cur.a0, cur.d_oe, cur.d_out,
                 cur.rsp, cur.busy, (!cur.busy && !(s2 && !vec_m)), rdata_m, vec_m, vdata_m};
        act_v = {cs_n[g], rd_n[g], wr_n[g], inta_n[g], a0[g], d_oe[g], d_out[g],
                 rsp_valid[g], busy[g], cmd_ready[g], rsp_rdata[g], vec_valid[g], vec_data[g]};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL g%0d_cycle t=%0t actual=%h required=%h", g, $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic do_cmd(input int g, input logic wr, input logic a, input logic [7:0] d,
                        output int waited);
    bit got;
    @(posedge clk); #2;
    cmd_valid[g] = 1'b1; cmd_write[g] = wr; cmd_a0[g] = a; cmd_wdata[g] = d;
    waited = 0; got = 1'b0;
    while (!got && waited < 60) begin
      @(negedge clk);
      if (cmd_ready[g]) got = 1'b1;
      else waited++;
    end
    if (!got) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #2;
    cmd_valid[g] = 1'b0;
  endtask

  task automatic pulse_vec_ready(input int g);
    @(posedge clk); #2 vec_ready[g] = 1'b1;
    @(posedge clk); #2 vec_ready[g] = 1'b0;
  endtask

  initial begin
    int w, lo, falls, n;
    logic cs_lo, oe_seen, rsp_seen, prev, found;
    logic [5:0] cs_t, wr_t, rsp_t, rdy_t, oe_t;

    cmd_valid = '0; cmd_write = '0; cmd_a0 = '0; int_in = '0; vec_ready = '0;
    for (int i = 0; i < NI; i++) begin
      cmd_wdata[i] = 8'h00; rd_val[i] = 8'hFF; vec_val[i] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {cmd_ready[0], busy[0], cs_n[0], wr_n[0], rd_n[0], inta_n[0], d_oe[0], vec_valid[0]},
        8'b10111100);
    repeat (2) @(posedge clk);

    // Write 0x13 at A0=0 on default timing; cycles 1..6 after the accept edge.
    cs_t = 6'b110000; wr_t = 6'b111001; rsp_t = 6'b001000; rdy_t = 6'b100000; oe_t = 6'b001111;
    do_cmd(0, 1'b1, 1'b0, 8'h13, w);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("wr_timing_c%0d", c + 1),
          {cs_n[0], wr_n[0], rsp_valid[0], cmd_ready[0], d_oe[0], d_out[0]},
          {cs_t[c], wr_t[c], rsp_t[c], rdy_t[c], oe_t[c], oe_t[c] ? 8'h13 : 8'h00});
    end

    // Read at A0=1 returning 0xA5.
    rd_val[0] = 8'hA5;
    do_cmd(0, 1'b0, 1'b1, 8'h00, w);
    lo = 0; oe_seen = 1'b0; found = 1'b0; n = 0;
    while (!found && n < 20) begin
      @(negedge clk); n++;
      if (!rd_n[0]) lo++;
      if (d_oe[0]) oe_seen = 1'b1;
      if (rsp_valid[0]) found = 1'b1;
    end
    chk("rd_rsp", {found, rsp_rdata[0], a0[0]}, {1'b1, 8'hA5, 1'b1});
    chk("rd_strobe_len", lo, 2);
    chk("rd_no_drive", oe_seen, 0);
    rd_val[0] = 8'hFF;
    repeat (3) @(posedge clk);

    // Interrupt acknowledge, vector 0x4B.
    vec_val[0] = 8'h4B;
    #2 int_in[0] = 1'b1;
    lo = 0; falls = 0; prev = 1'b1; cs_lo = 1'b0; found = 1'b0; n = 0;
    while (!found && n < 30) begin
      @(negedge clk); n++;
      if (!inta_n[0]) lo++;
      if (prev && !inta_n[0]) falls++;
      prev = inta_n[0];
      if (!cs_n[0]) cs_lo = 1'b1;
      if (vec_valid[0]) found = 1'b1;
    end
    chk("inta_vec", {found, vec_data[0]}, {1'b1, 8'h4B});
    chk("inta_shape", {falls[7:0], lo[7:0], 7'd0, cs_lo}, {8'd2, 8'd4, 8'd0});
    lo = 0;
    repeat (8) begin
      @(negedge clk);
      if (!inta_n[0]) lo++;
    end
    chk("no_second_inta", {lo[7:0], vec_valid[0], vec_data[0]}, {8'd0, 1'b1, 8'h4B});
    @(posedge clk); #2 int_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    pulse_vec_ready(0);
    @(negedge clk);
    chk("vec_cleared", vec_valid[0], 0);
    repeat (3) @(posedge clk);

    // INTA beats a command that arrives once int_s is up.
    vec_val[0] = 8'h61;
    @(posedge clk); #2 int_in[0] = 1'b1;
    @(posedge clk);
    do_cmd(0, 1'b1, 1'b1, 8'hFC, w);
    chk("inta_priority_wait", w, 7);
    int_in[0] = 1'b0;
    chk("inta_priority_vec", {vec_valid[0], vec_data[0]}, {1'b1, 8'h61});
    repeat (8) @(posedge clk);
    pulse_vec_ready(0);
    repeat (3) @(posedge clk);

    // Slow instance with auto-EOI: read first, then an acknowledge.
    rd_val[1] = 8'h5C;
    do_cmd(1, 1'b0, 1'b0, 8'h00, w);
    lo = 0; found = 1'b0; n = 0;
    while (!found && n < 20) begin
      @(negedge clk); n++;
      if (!rd_n[1]) lo++;
      if (rsp_valid[1]) found = 1'b1;
    end
    chk("g1_rd", {found, rsp_rdata[1], lo[7:0]}, {1'b1, 8'h5C, 8'd3});
    rd_val[1] = 8'hFF;
    repeat (4) @(posedge clk);

    vec_val[1] = 8'h39;
    #2 int_in[1] = 1'b1;
    rsp_seen = 1'b0; found = 1'b0; n = 0;
    while (!found && n < 60) begin
      @(negedge clk); n++;
      if (rsp_valid[1]) rsp_seen = 1'b1;
      if (!wr_n[1]) found = 1'b1;
    end
    chk("eoi_write", {found, cs_n[1], a0[1], d_oe[1], d_out[1]}, {1'b1, 1'b0, 1'b0, 1'b1, 8'h20});
    chk("eoi_vec", {vec_valid[1], vec_data[1]}, {1'b1, 8'h39});
    int_in[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid[1]) rsp_seen = 1'b1;
    end
    chk("eoi_no_rsp", rsp_seen, 0);
    pulse_vec_ready(1);
    repeat (3) @(posedge clk);

    // Asynchronous reset in the middle of a write strobe.
    do_cmd(0, 1'b1, 1'b1, 8'h77, w);
    found = 1'b0; n = 0;
    while (!found && n < 10) begin
      @(negedge clk); n++;
      if (!wr_n[0]) found = 1'b1;
    end
    chk("rst_reach_strobe", found, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {wr_n[0], cs_n[0], d_oe[0], busy[0], rsp_valid[0], d_out[0]}, {5'b11000, 8'h00});
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {cmd_ready[0], busy[0], rsp_rdata[0]}, {1'b1, 1'b0, 8'h00});

    do_cmd(0, 1'b1, 1'b0, 8'h5A, w);
    repeat (8) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_host_master.md
Name: pic_host_master

Overview:
- Clocked CPU-side bus initiator that drives the 8259-style PIC pins: CS/RD/WR/A0/D and INTA.
- Converts a simple valid/ready command interface into timed register write and read cycles (ICW/OCW programming, IRR/ISR/IMR reads).
- Watches the PIC INT output and runs the two-pulse INTA acknowledge sequence autonomously, then returns the captured vector byte.
- Optionally issues a non-specific EOI after each vector; sits between a host/test sequencer and the PIC top.

Parameters:
STROBE_CYCLES, 2, width of every RD/WR/INTA low pulse in clocks (>=1)
GAP_CYCLES, 1, recovery clocks with all strobes high after each cycle, and INTA1-to-INTA2 gap (>=1)
AUTO_EOI_CMD, 0, 1 = automatically write OCW2 0x20 (A0=0) after each acknowledged vector

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at rising edge
cmd_write  in  1  1=write, 0=read
cmd_a0  in  1  A0 value for the cycle
cmd_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse, read and write
rsp_rdata  out  8  read data, valid with rsp_valid, held until next read
int_in  in  1  PIC INT output (asynchronous)
vec_valid  out  1  vector available, held until vec_ready
vec_ready  in  1  vector consumed
vec_data  out  8  captured interrupt vector
cs_n  out  1  PIC chip select
rd_n  out  1  PIC read strobe
wr_n  out  1  PIC write strobe
a0  out  1  PIC address
inta_n  out  1  PIC interrupt acknowledge
d_out  out  8  data to PIC
d_oe  out  1  data bus drive enable (top-level tristate)
d_in  in  8  data from PIC
busy  out  1  state != IDLE

Behaviour:
- Clock clk, reset rst_n: asynchronous, active-low. Asserting reset at any time, including mid-strobe, immediately forces outputs: cs_n=rd_n=wr_n=inta_n=1, a0=0, d_oe=0, d_out=0, rsp_valid=0, rsp_rdata=0, vec_valid=0, vec_data=0, busy=0, state IDLE.
- int_in passes through a 2-flop synchroniser; int_s is the synchronised level, 2 clocks latency.
- States and sequencing:
  - IDLE -> INTA1 if int_s=1 and vec_valid=0; INTA has priority over commands.
  - IDLE -> SETUP otherwise, on command handshake.
  - cmd_ready = (state==IDLE) & ~(int_s & ~vec_valid). It is combinational from state, so it reads 1 after reset.
- Bus cycle, command latched at accept edge:
  - SETUP: 1 clk. cs_n=0, a0=cmd_a0; if write, d_out=wdata and d_oe=1.
  - STROBE: STROBE_CYCLES clks. wr_n=0 or rd_n=0; cs_n, a0 and data held. Reads sample d_in on the last STROBE clock.
  - HOLD: 1 clk. Strobe high, cs_n/a0/d_oe still held; rsp_valid=1 and rsp_rdata updated on reads.
  - RECOVER: GAP_CYCLES clks. All deasserted, d_oe=0. Then IDLE.
- Write timing with defaults: accept at edge 0 -> SETUP cyc1, wr_n low cyc2-3, rsp_valid cyc4, RECOVER cyc5, cmd_ready cyc6.
- INTA sequence (cs_n=1, d_oe=0 throughout):
  - INTA1: inta_n=0 for STROBE_CYCLES.
  - IGAP: GAP_CYCLES high.
  - INTA2: inta_n=0 for STROBE_CYCLES; sample d_in into vec_data on its last clock.
  - vec_valid=1 the next clock.
  - Then EOI write if AUTO_EOI_CMD: a normal write cycle, A0=0, data 0x20, no rsp_valid pulse. Else RECOVER.
- int_in falling after INTA1 starts does not abort the sequence; whatever d_in shows is captured (spurious IR7 vector is the host's concern).
- vec_valid clears on vec_valid&vec_ready. While vec_valid=1, no new INTA starts; commands are still served.
- rsp_valid is never asserted for INTA or auto-EOI cycles.
- Strobes never overlap: only one of rd_n, wr_n, inta_n is low at any time.
- Counters: a width covering max(STROBE_CYCLES, GAP_CYCLES); reload on state entry; no wrap past terminal count.

Test Plan:
- Write 0x13, A0=0 -> cs_n low cyc1-4, wr_n low exactly cyc2-3, d_out=0x13 with d_oe=1 cyc1-4, rsp_valid cyc4 only, cmd_ready back cyc6.
- Read A0=1 with d_in=0xA5 during strobe, 0xFF elsewhere -> rd_n low 2 clks, d_oe=0 throughout, rsp_rdata=0xA5 with rsp_valid.
- int_in=1, d_in=0x4B during INTA2 -> two inta_n pulses of 2 clks separated by 1 high clk, cs_n=1 throughout, vec_valid=1 with vec_data=0x4B, held until vec_ready.
- int_in and cmd_valid rising together -> INTA sequence first (cmd_ready=0), command executes after; int_in held with vec_ready=0 -> no second INTA.
- AUTO_EOI_CMD=1 -> after vector capture, write cycle a0=0, d_out=0x20, no rsp_valid pulse.
- rst_n low during wr_n=0 -> wr_n, cs_n, d_oe deassert same instant; after release cmd_ready=1, busy=0.
